encoder_emulator: RTL and testbench

ENCODER_EMULATOR -- requirements
Module: encoder_emulator

---
 rtl/encoder_emulator.sv | 135 +++++++++++++
 tb/tb_encoder_emulator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/encoder_emulator.sv
// Quadrature encoder emulator: turns step requests into A/B Gray-code edges,
// with optional LFSR-driven contact bounce on the changing line.
module encoder_emulator #(
  parameter int         BOUNCE_CYCLES = 16,
  parameter int         SETTLE_CYCLES = 32,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_valid,
  input  logic       step_dir,
  input  logic       bounce_en,
  output logic       step_ready,
  output logic       enc_a,
  output logic       enc_b,
  output logic [7:0] position
);

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

  localparam int CNT_W = 16;
  localparam bit HAS_BOUNCE = (BOUNCE_CYCLES > 0);
  localparam logic [CNT_W-1:0] BOUNCE_LOAD =
    (BOUNCE_CYCLES > 0) ? CNT_W'(BOUNCE_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] SETTLE_LOAD =
    (SETTLE_CYCLES > 1) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       phase_reg;
  logic [1:0]       target_reg;
  logic [1:0]       enc_reg;
  logic             dir_reg;
  logic             ready_reg;
  logic [7:0]       lfsr_reg;
  logic [7:0]       position_reg;

  logic       lfsr_fb;
  logic [7:0] lfsr_next;
  logic [1:0] accept_target;
  logic [1:0] bounce_target;
  logic [1:0] bounce_phase;

  // Gray-code walk: CW 00->01->11->10->00, CCW the reverse.
  function automatic logic [1:0] step_phase(input logic [1:0] p, input logic cw);
    logic [1:0] r;
    case (p)
      2'b00:   r = cw ? 2'b01 : 2'b10;
      2'b01:   r = cw ? 2'b11 : 2'b00;
      2'b11:   r = cw ? 2'b10 : 2'b01;
      default: r = cw ? 2'b00 : 2'b11;
    endcase
    return r;
  endfunction

  assign lfsr_fb       = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
  assign lfsr_next     = {lfsr_reg[6:0], lfsr_fb};
  assign accept_target = step_phase(phase_reg, step_dir);
  assign bounce_target = (state_reg == IDLE) ? accept_target : target_reg;

  // The enc register is loaded with the upcoming LFSR bit, so during BOUNCE
  // the changing line always equals the current lfsr[0].
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bounce
      assign bounce_phase[gi] = (phase_reg[gi] != bounce_target[gi]) ? lfsr_next[0]
                                                                     : phase_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      phase_reg    <= 2'b00;
      target_reg   <= 2'b00;
      enc_reg      <= 2'b00;
      dir_reg      <= 1'b0;
      ready_reg    <= 1'b1;
      lfsr_reg     <= LFSR_SEED;
      position_reg <= 8'd0;
    end else begin
      lfsr_reg <= lfsr_next;
      case (state_reg)
        IDLE: begin
          if (step_valid) begin
            target_reg <= accept_target;
            dir_reg    <= step_dir;
            ready_reg  <= 1'b0;
            if (bounce_en && HAS_BOUNCE) begin
              state_reg <= BOUNCE;
              cnt_reg   <= BOUNCE_LOAD;
              enc_reg   <= bounce_phase;
            end else begin
              state_reg <= SETTLE;
              cnt_reg   <= SETTLE_LOAD;
              enc_reg   <= accept_target;
              phase_reg <= accept_target;
            end
          end
        end
        BOUNCE: begin
          if (cnt_reg == '0) begin
            state_reg <= SETTLE;
            cnt_reg   <= SETTLE_LOAD;
            enc_reg   <= target_reg;
            phase_reg <= target_reg;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
            enc_reg <= bounce_phase;
          end
        end
        SETTLE: begin
          if (cnt_reg == '0) begin
            state_reg    <= IDLE;
            ready_reg    <= 1'b1;
            position_reg <= dir_reg ? position_reg + 8'd1 : position_reg - 8'd1;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign step_ready = ready_reg;
  assign enc_a      = enc_reg[1];
  assign enc_b      = enc_reg[0];
  assign position   = position_reg;

endmodule

// File: tb/tb_encoder_emulator.sv
// Randomized self-checking bench for encoder_emulator against a step-level
// reference model (phase index, remaining busy/bounce cycles, software LFSR).
module tb_encoder_emulator;
  localparam int B = 16;
  localparam int S = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       step_valid = 1'b0;
  logic       step_dir = 1'b0;
  logic       bounce_en = 1'b0;
  logic       step_ready;
  logic       enc_a;
  logic       enc_b;
  logic [7:0] position;

  int n_checks = 0;
  int n_fail   = 0;

  encoder_emulator #(
    .BOUNCE_CYCLES(B),
    .SETTLE_CYCLES(S),
    .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .step_valid(step_valid),
    .step_dir(step_dir),
    .bounce_en(bounce_en),
    .step_ready(step_ready),
    .enc_a(enc_a),
    .enc_b(enc_b),
    .position(position)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase as an index into the Gray sequence, step duration
  // as a countdown of remaining busy cycles.
  logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int         m_idx, m_old, m_busy, m_bounce, m_pos;
  logic       m_dir;
  logic [7:0] m_lfsr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_idx = 0; m_old = 0; m_busy = 0; m_bounce = 0; m_pos = 0; m_dir = 1'b0;
      m_lfsr = 8'hA5;
    end else begin
      if (m_busy > 0) begin
        m_busy--;
        if (m_bounce > 0) m_bounce--;
        if (m_busy == 0) m_pos = (m_pos + (m_dir ? 1 : 255)) % 256;
      end else if (step_valid) begin
        m_dir    = step_dir;
        m_old    = m_idx;
        m_idx    = (m_idx + (step_dir ? 1 : 3)) % 4;
        m_bounce = (bounce_en && B > 0) ? B : 0;
        m_busy   = m_bounce + S;
      end
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  logic [1:0] c_old, c_new, c_mask, c_exp;
  always @(negedge clk) begin
    c_old = seq[m_old];
    c_new = seq[m_idx];
    c_mask = c_old ^ c_new;
    c_exp = (m_bounce > 0) ? ((c_old & ~c_mask) | (c_mask & {2{m_lfsr[0]}})) : c_new;
    check("enc_ab", {30'd0, enc_a, enc_b}, {30'd0, c_exp});
    check("step_ready", {31'd0, step_ready}, {31'd0, (m_busy == 0)});
    check("position", {24'd0, position}, m_pos);
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while (step_ready !== 1'b1 && n < 1000) begin
      n++;
      @(posedge clk); #1;
    end
    if (step_ready !== 1'b1) check({tag, " idle_timeout"}, {31'd0, step_ready}, 32'd1);
  endtask

  task automatic do_step(input logic dir, input logic bnc, input int exp_low, input string tag);
    int low = 0;
    @(posedge clk); #1;
    step_valid = 1'b1; step_dir = dir; bounce_en = bnc;
    @(posedge clk); #1;
    step_valid = 1'b0;
    while (step_ready !== 1'b1 && low < 1000) begin
      low++;
      @(posedge clk); #1;
    end
    check({tag, " ready_low"}, low, exp_low);
  endtask

  // Asserts reset between edges and checks outputs before any clock edge.
  task automatic pulse_reset(input string tag);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check({tag, " rst_enc"}, {30'd0, enc_a, enc_b}, 32'd0);
    check({tag, " rst_ready"}, {31'd0, step_ready}, 32'd1);
    check({tag, " rst_pos"}, {24'd0, position}, 32'd0);
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  logic [1:0] cw_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  initial begin
    #23;
    check("init enc", {30'd0, enc_a, enc_b}, 32'd0);
    check("init ready", {31'd0, step_ready}, 32'd1);
    check("init pos", {24'd0, position}, 32'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("model lfsr first step", {24'd0, m_lfsr}, 32'h4A);

    // Four clean CW steps walk the full Gray cycle.
    for (int i = 0; i < 4; i++) begin
      do_step(1'b1, 1'b0, S, "cw");
      check("cw enc", {30'd0, enc_a, enc_b}, {30'd0, cw_seq[i]});
    end
    check("cw pos", {24'd0, position}, 32'd4);

    // CCW from reset wraps to 255, CW back wraps to 0.
    pulse_reset("ccw");
    do_step(1'b0, 1'b0, S, "ccw");
    check("ccw enc", {30'd0, enc_a, enc_b}, 32'b10);
    check("ccw pos", {24'd0, position}, 32'd255);
    do_step(1'b1, 1'b0, S, "wrap");
    check("wrap pos", {24'd0, position}, 32'd0);

    // Bounced CW step.
    pulse_reset("bnc");
    do_step(1'b1, 1'b1, B + S, "bnc");
    check("bnc enc", {30'd0, enc_a, enc_b}, 32'b01);
    check("bnc pos", {24'd0, position}, 32'd1);

    // step_valid held high, direction toggling every cycle.
    step_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      step_dir  = ~step_dir;
      bounce_en = 1'($urandom_range(0, 1));
    end
    step_valid = 1'b0;
    wait_idle("hold");

    // Reset five cycles into BOUNCE, request pending through reset.
    @(posedge clk); #1;
    step_valid = 1'b1; step_dir = 1'b1; bounce_en = 1'b1;
    @(posedge clk); #1;
    step_valid = 1'b0;
    repeat (4) @(posedge clk);
    step_valid = 1'b1;
    pulse_reset("midbnc");
    @(posedge clk); #1;
    step_valid = 1'b0;
    check("post-rst accept ready", {31'd0, step_ready}, 32'd0);
    check("post-rst bounce 1", {30'd0, enc_a, enc_b}, 32'b00);
    @(posedge clk); #1;
    check("post-rst bounce 2", {30'd0, enc_a, enc_b}, 32'b01);
    wait_idle("midbnc");
    check("midbnc pos", {24'd0, position}, 32'd1);

    // Randomized traffic with rare mid-cycle reset pulses.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      step_valid = ($urandom_range(0, 2) == 0);
      step_dir   = 1'($urandom_range(0, 1));
      bounce_en  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 400) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end
    step_valid = 1'b0;
    wait_idle("random");

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
